riscv_if_fetch: RTL and testbench
=================================

// Module: riscv_if_fetch
// PURPOSE
//  Instruction-fetch stage: generates fetch PCs, issues in-order requests to instruction memory,
//  buffers returned words in a DEPTH-entry queue and presents the head to the pre-decode stage
//  as {if_pc_o, if_insn_o, exceptions}. Handles redirects from state, branch unit and pre-decode
//  prediction, discarding stale queued and in-flight words.
// PARAMETERS
//  XLEN     32      address/PC width
//  PC_INIT  'h200   first fetch PC after reset
//  DEPTH    2       queue entries and max outstanding requests; power of 2, >=2
// PORTS
//  clk_i              in   1     clock
//  rst_i              in   1     synchronous active-high reset
//  imem_req_o         out  1     fetch request valid
//  imem_adr_o         out  XLEN  fetch address, word aligned
//  imem_gnt_i         in   1     request accepted this cycle (req & gnt = issue)
//  imem_ack_i         in   1     response valid; responses return in issue order, >=1 cycle later
//  imem_rdata_i       in   32    response instruction word
//  imem_err_i         in   1     response bus error (qualified by ack)
//  st_flush_i         in   1     state redirect to st_nxt_pc_i
//  st_nxt_pc_i        in   XLEN
//  bu_flush_i         in   1     branch-unit redirect to bu_nxt_pc_i
//  bu_nxt_pc_i        in   XLEN
//  pd_latch_nxt_pc_i  in   1     pre-decode predicted-taken redirect to pd_nxt_pc_i
//  pd_nxt_pc_i        in   XLEN
//  pd_stall_i         in   1     pre-decode cannot accept head this cycle
//  if_pc_o            out  XLEN  PC of head entry
//  if_insn_o          out  instruction_t  {instr, bubble} of head entry
//  if_misaligned_o    out  1     head carries instruction-address-misaligned exception
//  if_bus_err_o       out  1     head carries instruction access fault
// BEHAVIOUR
//  Reset: imem_req_o=0, fetch_pc=PC_INIT, queue empty, outstanding=0, kill=0,
//   if_insn_o={INSTR_NOP,bubble=1}, if_pc_o=PC_INIT, exception outputs 0. Requests start the cycle after rst_i falls.
//  Issue: imem_req_o=1 when !halted and occupancy+outstanding<DEPTH; on req&gnt fetch_pc+=4,
//   outstanding++. imem_adr_o=fetch_pc (held stable until gnt).
//  Return: on ack, outstanding--; if kill>0 then kill-- and word dropped, else push
//   {pc,word,err}. ack with err: entry pushed with bus_err=1, fetching halts until next redirect.
//  Output: head of queue, registered storage (ack in cycle N -> visible on if_* in N+1).
//   Empty -> bubble=1, instr=INSTR_NOP. Head popped when !bubble & !pd_stall_i.
//  Redirect priority: st_flush_i > bu_flush_i > pd_latch_nxt_pc_i; same cycle as push/pop/issue.
//   st/bu: clear whole queue, kill=outstanding-(ack this cycle), fetch_pc=target, halted=0; no issue that cycle.
//   pd: head entry kept (it is the predicted branch, popped normally); all younger entries cleared;
//   in-flight words killed as above; fetch_pc=pd_nxt_pc_i.
//  Misaligned target (target[1:0]!=0): no request; push one entry {pc=target, instr=INSTR_NOP,
//   misaligned=1, bubble=0}; halt until next redirect.
//  Requests are never withdrawn: a redirect arriving while req pending without gnt drops req
//   only because the target changes; the previous address is never granted afterwards.
//  Queue full and pd_stall_i: no issue; occupancy+outstanding never exceeds DEPTH (assertion).
//  fetch_pc wraps modulo 2^XLEN.
//  Reset mid-operation: all state to reset values; subsequent acks for pre-reset requests are
//   not generated by memory (memory reset with same rst_i).
// STRUCTURE
//  riscv_state_pkg: if_entry_t {pc, instr, misaligned, bus_err}; reuse INSTR_NOP, instruction_t.
//  Sub-module riscv_if_queue: DEPTH-entry FIFO of if_entry_t with push, pop, flush_all,
//   flush_younger (keep head) and occupancy output. Top holds PC, outstanding/kill counters, halt.
// TESTING
//  1 Reset, gnt=1, ack 1-cycle latency, no stall -> PCs 200,204,208.. back-to-back, bubble=0 from cycle 3.
//  2 pd_stall_i held 5 cycles -> issue stops at DEPTH total, head stable, no word lost on release.
//  3 bu_flush_i to 'h400 with 2 requests in flight -> both acks dropped, next head pc=400.
//  4 pd_latch_nxt_pc_i to 'h300 with head=208 and 20C queued -> 208 delivered, next head 300.
//  5 st_flush_i and bu_flush_i same cycle (st 'h100, bu 'h500) -> next head pc=100.
//  6 redirect to 'h402 -> single entry misaligned=1 pc=402, no imem_req_o until next flush; ack with
//    imem_err_i at 'h600 -> bus_err=1 entry, fetch halted.

Source files
------------

// File: rtl/riscv_state_pkg.sv
// Shared fetch-side types: instruction word with bubble flag and the fetch queue entry.
package riscv_state_pkg;

    localparam int          IF_XLEN   = 32;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic        bubble;
    } instruction_t;

    typedef struct packed {
        logic [IF_XLEN-1:0] pc;
        logic [31:0]        instr;
        logic               misaligned;
        logic               bus_err;
    } if_entry_t;

endpackage

// File: rtl/riscv_if_queue.sv
// DEPTH-entry FIFO of fetched words; flush_younger keeps only the head entry.
module riscv_if_queue
    import riscv_state_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  if_entry_t push_entry,
    input  logic      pop,
    input  logic      flush_all,
    input  logic      flush_younger,
    output if_entry_t head,
    output logic      empty,
    output logic [PW:0] occupancy
);

    if_entry_t     mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          do_pop;

    assign do_pop    = pop && (count != '0);
    assign wr_ptr    = rd_ptr + count[PW-1:0];
    assign head      = mem[rd_ptr];
    assign empty     = (count == '0);
    assign occupancy = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_all) begin
            count <= '0;
        end else if (flush_younger) begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                count  <= '0;
            end else begin
                count <= (PW+1)'(count != '0);
            end
        end else begin
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(do_pop);
        end
    end

    // Storage needs no reset: the head is only observed when count is non-zero.
    always_ff @(posedge clk) begin
        if (push && !flush_all && !flush_younger)
            mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/riscv_if_fetch.sv
// Instruction-fetch stage: PC generation, in-order imem requests, redirect handling
// and a small queue feeding pre-decode.
module riscv_if_fetch
    import riscv_state_pkg::*;
#(
    parameter int               XLEN    = 32,
    parameter logic [XLEN-1:0]  PC_INIT = 'h200,
    parameter int               DEPTH   = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_adr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_ack_i,
    input  logic [31:0]     imem_rdata_i,
    input  logic            imem_err_i,
    input  logic            st_flush_i,
    input  logic [XLEN-1:0] st_nxt_pc_i,
    input  logic            bu_flush_i,
    input  logic [XLEN-1:0] bu_nxt_pc_i,
    input  logic            pd_latch_nxt_pc_i,
    input  logic [XLEN-1:0] pd_nxt_pc_i,
    input  logic            pd_stall_i,
    output logic [XLEN-1:0] if_pc_o,
    output instruction_t    if_insn_o,
    output logic            if_misaligned_o,
    output logic            if_bus_err_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 2;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] ret_pc;
    logic [XLEN-1:0] target;
    logic [PW:0]     outstanding;
    logic [PW:0]     kill;
    logic [PW:0]     occupancy;
    logic            halted;
    logic            flush_hard;
    logic            redirect;
    logic            empty;
    logic            pop;
    logic            room;
    logic            misaligned_pc;
    logic            issue;
    logic            push_word;
    logic            push_mis;
    if_entry_t       head;
    if_entry_t       push_entry;

    always_comb begin
        flush_hard = st_flush_i | bu_flush_i;
        redirect   = flush_hard | pd_latch_nxt_pc_i;
        if (st_flush_i)
            target = st_nxt_pc_i;
        else if (bu_flush_i)
            target = bu_nxt_pc_i;
        else
            target = pd_nxt_pc_i;
    end

    // A pop this cycle frees a slot, so issue can keep pace with a 1-cycle memory.
    assign pop           = !empty && !pd_stall_i;
    assign room          = (CW'(occupancy) + CW'(outstanding) - CW'(pop)) < CW'(DEPTH);
    assign misaligned_pc = (fetch_pc[1:0] != 2'b00);

    assign imem_req_o = !rst_i && !halted && !misaligned_pc && room && !redirect;
    assign imem_adr_o = fetch_pc;
    assign issue      = imem_req_o && imem_gnt_i;

    // ret_pc tracks the PC of the next word that will survive the kill count.
    assign push_word = imem_ack_i && (kill == '0) && !redirect;
    assign push_mis  = !halted && misaligned_pc && room && !redirect && !push_word;

    always_comb begin
        push_entry.pc         = ret_pc;
        push_entry.instr      = imem_rdata_i;
        push_entry.misaligned = 1'b0;
        push_entry.bus_err    = imem_err_i;
        if (push_mis) begin
            push_entry.pc         = fetch_pc;
            push_entry.instr      = INSTR_NOP;
            push_entry.misaligned = 1'b1;
            push_entry.bus_err    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc    <= PC_INIT;
            ret_pc      <= PC_INIT;
            outstanding <= '0;
            kill        <= '0;
            halted      <= 1'b0;
        end else begin
            outstanding <= outstanding + (PW+1)'(issue) - (PW+1)'(imem_ack_i);
            if (redirect) begin
                fetch_pc <= target;
                ret_pc   <= target;
                halted   <= 1'b0;
                kill     <= outstanding - (PW+1)'(imem_ack_i);
            end else begin
                if (issue)
                    fetch_pc <= fetch_pc + XLEN'(4);
                if (imem_ack_i && (kill != '0))
                    kill <= kill - (PW+1)'(1);
                if (push_word)
                    ret_pc <= ret_pc + XLEN'(4);
                if ((push_word && imem_err_i) || push_mis)
                    halted <= 1'b1;
            end
        end
    end

    riscv_if_queue #(.DEPTH(DEPTH)) u_queue (
        .clk           (clk_i),
        .rst           (rst_i),
        .push          (push_word | push_mis),
        .push_entry    (push_entry),
        .pop           (pop),
        .flush_all     (flush_hard),
        .flush_younger (pd_latch_nxt_pc_i && !flush_hard),
        .head          (head),
        .empty         (empty),
        .occupancy     (occupancy)
    );

    assign if_pc_o          = empty ? ret_pc : head.pc;
    assign if_insn_o.instr  = empty ? INSTR_NOP : head.instr;
    assign if_insn_o.bubble = empty;
    assign if_misaligned_o  = !empty && head.misaligned;
    assign if_bus_err_o     = !empty && head.bus_err;

    always_ff @(posedge clk_i) begin
        if (!rst_i)
            assert (CW'(occupancy) + CW'(outstanding) <= CW'(DEPTH));
    end

endmodule

// File: tb/tb_riscv_if_fetch.sv
// Directed bench for riscv_if_fetch with an in-order, 1-cycle-latency memory responder.
module tb_riscv_if_fetch;
    import riscv_state_pkg::*;

    localparam logic [31:0] DATA_OFS = 32'h1000_0000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         imem_req;
    logic [31:0]  imem_adr;
    logic         imem_gnt = 1'b0;
    logic         imem_ack = 1'b0;
    logic [31:0]  imem_rdata = '0;
    logic         imem_err = 1'b0;
    logic         st_flush = 1'b0;
    logic [31:0]  st_nxt_pc = '0;
    logic         bu_flush = 1'b0;
    logic [31:0]  bu_nxt_pc = '0;
    logic         pd_latch = 1'b0;
    logic [31:0]  pd_nxt_pc = '0;
    logic         pd_stall = 1'b0;
    logic [31:0]  if_pc;
    instruction_t if_insn;
    logic         if_misaligned;
    logic         if_bus_err;

    logic         gnt_en = 1'b1;
    logic         ack_en = 1'b1;
    logic [31:0]  err_adr = 32'hFFFF_FFFF;
    logic [31:0]  pending[$];
    int           n_issue = 0;
    int           n_assert = 0;
    int           n_fail = 0;
    int           n_mark;

    always #5 clk = ~clk;

    riscv_if_fetch dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .imem_req_o        (imem_req),
        .imem_adr_o        (imem_adr),
        .imem_gnt_i        (imem_gnt),
        .imem_ack_i        (imem_ack),
        .imem_rdata_i      (imem_rdata),
        .imem_err_i        (imem_err),
        .st_flush_i        (st_flush),
        .st_nxt_pc_i       (st_nxt_pc),
        .bu_flush_i        (bu_flush),
        .bu_nxt_pc_i       (bu_nxt_pc),
        .pd_latch_nxt_pc_i (pd_latch),
        .pd_nxt_pc_i       (pd_nxt_pc),
        .pd_stall_i        (pd_stall),
        .if_pc_o           (if_pc),
        .if_insn_o         (if_insn),
        .if_misaligned_o   (if_misaligned),
        .if_bus_err_o      (if_bus_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive memory response and control, record any issue, return 1ns after the edge.
    task automatic cyc();
        logic [31:0] a;
        if (rst) pending.delete();
        if (rst || !ack_en || pending.size() == 0) begin
            imem_ack   = 1'b0;
            imem_err   = 1'b0;
            imem_rdata = '0;
        end else begin
            a          = pending.pop_front();
            imem_ack   = 1'b1;
            imem_rdata = a + DATA_OFS;
            imem_err   = (a == err_adr);
        end
        imem_gnt = gnt_en;
        #1;
        if (!rst && imem_req && imem_gnt) begin
            pending.push_back(imem_adr);
            n_issue++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, "_bubble"}, 64'(if_insn.bubble), 64'(0));
        chk({tag, "_pc"}, 64'(if_pc), 64'(pc));
        chk({tag, "_insn"}, 64'(if_insn.instr), 64'(pc + DATA_OFS));
    endtask

    initial begin
        // reset state
        rst = 1'b1;
        cyc(); cyc();
        chk("rst_req", 64'(imem_req), 64'(0));
        chk("rst_bubble", 64'(if_insn.bubble), 64'(1));
        chk("rst_instr", 64'(if_insn.instr), 64'(INSTR_NOP));
        chk("rst_pc", 64'(if_pc), 64'(32'h200));
        chk("rst_mis", 64'(if_misaligned), 64'(0));
        chk("rst_err", 64'(if_bus_err), 64'(0));

        // back-to-back stream
        rst = 1'b0;
        cyc();
        chk("t1_first_bubble", 64'(if_insn.bubble), 64'(1));
        cyc(); chk_head("t1_h200", 32'h200);
        cyc(); chk_head("t1_h204", 32'h204);
        cyc(); chk_head("t1_h208", 32'h208);

        // stall 5 cycles: queue fills, issue stops, head stays
        pd_stall = 1'b1;
        n_mark = n_issue;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t2_stall_head", 64'(if_pc), 64'(32'h208));
        end
        chk("t2_stall_req", 64'(imem_req), 64'(0));
        chk("t2_stall_issues", 64'(n_issue), 64'(n_mark));
        pd_stall = 1'b0;
        cyc(); chk_head("t2_rel_h20c", 32'h20C);
        cyc(); chk_head("t2_rel_h210", 32'h210);

        // branch redirect with two words in flight
        ack_en = 1'b0;
        cyc(); cyc();
        chk("t3_inflight", 64'(pending.size()), 64'(2));
        n_mark = n_issue;
        bu_flush = 1'b1; bu_nxt_pc = 32'h400;
        cyc();
        bu_flush = 1'b0; ack_en = 1'b1;
        chk("t3_no_issue_on_flush", 64'(n_issue), 64'(n_mark));
        cyc(); chk("t3_drop1", 64'(if_insn.bubble), 64'(1));
        cyc(); chk("t3_drop2", 64'(if_insn.bubble), 64'(1));
        cyc(); chk_head("t3_h400", 32'h400);

        // reset mid-operation, then predicted-taken redirect
        rst = 1'b1;
        cyc();
        chk("t4_rst_bubble", 64'(if_insn.bubble), 64'(1));
        chk("t4_rst_pc", 64'(if_pc), 64'(32'h200));
        rst = 1'b0;
        cyc(); cyc(); cyc(); cyc();
        chk_head("t4_h208", 32'h208);
        pd_stall = 1'b1;
        cyc();
        chk("t4_full_head", 64'(if_pc), 64'(32'h208));
        pd_latch = 1'b1; pd_nxt_pc = 32'h300;
        cyc();
        pd_latch = 1'b0;
        chk_head("t4_kept_h208", 32'h208);
        pd_stall = 1'b0;
        cyc();
        chk("t4_20c_cleared", 64'(if_insn.bubble), 64'(1));
        cyc(); chk_head("t4_h300", 32'h300);

        // st and bu together: st wins
        st_flush = 1'b1; st_nxt_pc = 32'h100;
        bu_flush = 1'b1; bu_nxt_pc = 32'h500;
        cyc();
        st_flush = 1'b0; bu_flush = 1'b0;
        chk("t5_flushed", 64'(if_insn.bubble), 64'(1));
        cyc();
        cyc(); chk_head("t5_h100", 32'h100);

        // misaligned target
        bu_flush = 1'b1; bu_nxt_pc = 32'h402;
        cyc();
        bu_flush = 1'b0;
        n_mark = n_issue;
        cyc();
        chk("t6_mis_bubble", 64'(if_insn.bubble), 64'(0));
        chk("t6_mis_pc", 64'(if_pc), 64'(32'h402));
        chk("t6_mis_flag", 64'(if_misaligned), 64'(1));
        chk("t6_mis_instr", 64'(if_insn.instr), 64'(INSTR_NOP));
        chk("t6_mis_err", 64'(if_bus_err), 64'(0));
        cyc();
        chk("t6_mis_single", 64'(if_insn.bubble), 64'(1));
        cyc(); cyc();
        chk("t6_mis_req", 64'(imem_req), 64'(0));
        chk("t6_mis_issues", 64'(n_issue), 64'(n_mark));

        // bus error halts fetching
        err_adr = 32'h600;
        bu_flush = 1'b1; bu_nxt_pc = 32'h600;
        cyc();
        bu_flush = 1'b0;
        cyc();
        cyc();
        chk("t6_err_pc", 64'(if_pc), 64'(32'h600));
        chk("t6_err_flag", 64'(if_bus_err), 64'(1));
        chk("t6_err_bubble", 64'(if_insn.bubble), 64'(0));
        chk("t6_err_mis", 64'(if_misaligned), 64'(0));
        cyc();
        n_mark = n_issue;
        cyc(); cyc();
        chk("t6_err_req", 64'(imem_req), 64'(0));
        chk("t6_err_issues", 64'(n_issue), 64'(n_mark));
        bu_flush = 1'b1; bu_nxt_pc = 32'h700;
        cyc();
        bu_flush = 1'b0;
        cyc();
        chk("t6_resume_issue", 64'(n_issue), 64'(n_mark + 1));
        chk("t6_resume_adr", 64'(imem_adr), 64'(32'h704));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
